// File: rtl/commit_unit_pkg.sv
// Shared ROB-entry and commit-stage types.
// itype encodings: BRANCH=00, STORE=01, REG/LOAD=1x.
package commit_unit_pkg;

    localparam int unsigned ROB_VALUE_W = 32;
    localparam int unsigned ROB_TAG_W   = 4;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MISP_CNT_W  = 16;

    typedef enum logic [1:0] {
        IT_BRANCH = 2'b00,
        IT_STORE  = 2'b01,
        IT_REG    = 2'b10,
        IT_LOAD   = 2'b11
    } itype_t;

    typedef struct packed {
        itype_t                  itype;
        logic [ROB_TAG_W-1:0]    ROB_number;
        logic [ROB_VALUE_W-1:0]  value;
        logic [REG_ADDR_W-1:0]   dest_reg;
        logic                    branch_result;
    } ROB_entry_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STORE_WAIT,
        ST_FLUSH
    } commit_state_t;

endpackage

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, writes the register file,
// hands stores to the load/store queue and flushes on branch mispredicts.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  ROB_entry_t             head,
    input  logic                   head_ready,
    input  logic                   empty,
    input  logic                   ROB_head_store,
    output logic                   rd_en,
    output logic                   rf_we,
    output logic [REG_ADDR_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [ROB_TAG_W-1:0]   rf_rob_tag,
    output logic                   st_req,
    output logic [ROB_TAG_W-1:0]   st_rob,
    input  logic                   st_ack,
    output logic                   flush,
    output logic [XLEN-1:0]        redirect_pc,
    output logic [CNT_W-1:0]       retired_cnt,
    output logic [MISP_CNT_W-1:0]  mispredict_cnt
);

    commit_state_t state;
    commit_state_t state_next;

    logic commit_ok;
    logic is_reg;
    logic is_branch;
    logic entering_store;
    logic entering_flush;

    // reset masks the combinational commit so no dequeue is seen while held
    assign commit_ok      = head_ready && !empty && !reset;
    assign is_reg         = head.itype[1];
    assign is_branch      = (head.itype == IT_BRANCH);
    assign entering_store = (state == ST_RUN) && (state_next == ST_STORE_WAIT);
    assign entering_flush = (state == ST_RUN) && (state_next == ST_FLUSH);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (commit_ok) begin
                    if (ROB_head_store) begin
                        state_next = ST_STORE_WAIT;
                    end else if (is_branch && head.branch_result) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_STORE_WAIT: begin
                if (st_ack) begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Combinational commit outputs
    always_comb begin
        rd_en      = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = head.dest_reg;
        rf_wdata   = XLEN'(head.value);
        rf_rob_tag = head.ROB_number;
        case (state)
            ST_RUN: begin
                if (commit_ok && !ROB_head_store) begin
                    if (is_reg) begin
                        rd_en = 1'b1;
                        rf_we = (head.dest_reg != '0);
                    end else if (is_branch) begin
                        rd_en = 1'b1;
                    end
                end
            end
            ST_STORE_WAIT: rd_en = st_ack && !reset;
            default:       rd_en = 1'b0;
        endcase
    end

    // Registered handshake, redirect and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            st_req         <= 1'b0;
            st_rob         <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            retired_cnt    <= '0;
            mispredict_cnt <= '0;
        end else begin
            st_req <= (state_next == ST_STORE_WAIT);
            flush  <= (state_next == ST_FLUSH);
            if (entering_store) begin
                st_rob <= head.ROB_number;
            end
            if (entering_flush) begin
                redirect_pc <= XLEN'(head.value);
                if (mispredict_cnt != '1) begin
                    mispredict_cnt <= mispredict_cnt + MISP_CNT_W'(1);
                end
            end
            if (rd_en) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed table, multi-cycle
// sequences and random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_commit_unit;
    import commit_unit_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    ROB_entry_t        head;
    logic              head_ready;
    logic              empty;
    logic              ROB_head_store;
    logic              st_ack;
    logic              rd_en;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [3:0]        rf_rob_tag;
    logic              st_req;
    logic [3:0]        st_rob;
    logic              flush;
    logic [XLEN-1:0]   redirect_pc;
    logic [CNT_W-1:0]  retired_cnt;
    logic [15:0]       mispredict_cnt;

    commit_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .head(head), .head_ready(head_ready),
        .empty(empty), .ROB_head_store(ROB_head_store), .rd_en(rd_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rob_tag(rf_rob_tag), .st_req(st_req), .st_rob(st_rob),
        .st_ack(st_ack), .flush(flush), .redirect_pc(redirect_pc),
        .retired_cnt(retired_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an outstanding store, a scheduled flush, counters.
    logic              m_store_out;
    logic [3:0]        m_st_rob;
    logic              m_flush;
    logic [XLEN-1:0]   m_pc;
    logic [CNT_W-1:0]  m_retired;
    logic [15:0]       m_mis;

    logic              s_rd, s_we, s_st_req, s_flush;
    logic [4:0]        s_waddr;
    logic [XLEN-1:0]   s_wdata, s_pc;
    logic [3:0]        s_st_rob;
    logic [CNT_W-1:0]  s_ret;
    logic [15:0]       s_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input itype_t it, input logic [3:0] rn,
                         input logic [31:0] val, input logic [4:0] dr, input logic br,
                         input logic rdy, input logic emp, input logic ack);
        reset              = rst;
        head.itype         = it;
        head.ROB_number    = rn;
        head.value         = val;
        head.dest_reg      = dr;
        head.branch_result = br;
        head_ready         = rdy;
        empty              = emp;
        ROB_head_store     = (it == IT_STORE);
        st_ack             = ack;
    endtask

    // One clock: compare DUT with the model, advance the model, cross the edge.
    task automatic run_cycle();
        logic             commit, e_rd, e_we;
        logic             n_store, n_flush;
        logic [3:0]       n_st_rob;
        logic [XLEN-1:0]  n_pc;
        logic [CNT_W-1:0] n_ret;
        logic [15:0]      n_mis;
        #2;
        commit = head_ready && !empty;
        e_rd = 1'b0;
        e_we = 1'b0;
        if (!reset) begin
            if (m_flush) begin
                e_rd = 1'b0;
            end else if (m_store_out) begin
                e_rd = st_ack;
            end else if (commit && !ROB_head_store) begin
                if (head.itype[1]) begin
                    e_rd = 1'b1;
                    e_we = (head.dest_reg != 5'd0);
                end else if (head.itype == IT_BRANCH) begin
                    e_rd = 1'b1;
                end
            end
        end
        s_rd = rd_en; s_we = rf_we; s_st_req = st_req; s_flush = flush;
        s_waddr = rf_waddr; s_wdata = rf_wdata; s_pc = redirect_pc;
        s_st_rob = st_rob; s_ret = retired_cnt; s_mis = mispredict_cnt;
        chk("rd_en", rd_en, e_rd);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, head.dest_reg);
            chk("rf_wdata", rf_wdata, head.value);
            chk("rf_rob_tag", rf_rob_tag, head.ROB_number);
        end
        chk("st_req", st_req, m_store_out);
        chk("st_rob", st_rob, m_st_rob);
        chk("flush", flush, m_flush);
        chk("redirect_pc", redirect_pc, m_pc);
        chk("retired_cnt", retired_cnt, m_retired);
        chk("mispredict_cnt", mispredict_cnt, m_mis);

        n_store = m_store_out; n_flush = 1'b0; n_st_rob = m_st_rob;
        n_pc = m_pc; n_mis = m_mis; n_ret = m_retired + CNT_W'(e_rd);
        if (m_store_out && st_ack) n_store = 1'b0;
        if (!m_flush && !m_store_out && commit) begin
            if (ROB_head_store) begin
                n_store  = 1'b1;
                n_st_rob = head.ROB_number;
            end else if (head.itype == IT_BRANCH && head.branch_result) begin
                n_flush = 1'b1;
                n_pc    = head.value;
                n_mis   = (m_mis == 16'hFFFF) ? m_mis : m_mis + 16'd1;
            end
        end
        if (reset) begin
            n_store = 1'b0; n_flush = 1'b0; n_st_rob = '0;
            n_pc = '0; n_mis = '0; n_ret = '0;
        end
        @(posedge clk);
        #1;
        m_store_out = n_store; m_flush = n_flush; m_st_rob = n_st_rob;
        m_pc = n_pc; m_mis = n_mis; m_retired = n_ret;
    endtask

    task automatic idle(input logic rst);
        drive(rst, IT_REG, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        itype_t      it;
        logic [3:0]  rn;
        logic [31:0] val;
        logic [4:0]  dr;
        logic        br, rdy, emp, ack;
        logic        exp_rd, exp_we;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int hi_cnt;
        vecs[0] = '{IT_REG,    4'd3, 32'hDEAD_BEEF, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{IT_LOAD,   4'd4, 32'h1111_2222, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{IT_REG,    4'd5, 32'h3333_4444, 5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{IT_REG,    4'd6, 32'h5555_6666, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{IT_BRANCH, 4'd8, 32'h0000_0800, 5'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{IT_LOAD,   4'd9, 32'h0000_1234, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{IT_BRANCH, 4'd2, 32'h0000_0C00, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        m_store_out = 1'b0; m_st_rob = '0; m_flush = 1'b0;
        m_pc = '0; m_retired = '0; m_mis = '0;
        run_cycle();

        // Directed single-cycle vectors in RUN
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, vecs[i].it, vecs[i].rn, vecs[i].val, vecs[i].dr, vecs[i].br,
                  vecs[i].rdy, vecs[i].emp, vecs[i].ack);
            run_cycle();
            chk("tbl_rd_en", s_rd, vecs[i].exp_rd);
            chk("tbl_rf_we", s_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk("tbl_rf_waddr", s_waddr, vecs[i].dr);
                chk("tbl_rf_wdata", s_wdata, vecs[i].val);
            end
            if (i == 0) chk("tbl_retired_after_first", retired_cnt, 1);
        end

        // Store: st_req held three cycles, ack on the third; head changes ignored
        drive(1'b0, IT_STORE, 4'd7, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle();
        chk("store_issue_rd_en", s_rd, 0);
        hi_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, IT_REG, 4'd2, 32'hABCD, 5'd3, 1'b0, 1'b1, 1'b0, (c == 2));
            run_cycle();
            if (s_st_req) hi_cnt++;
            chk("store_st_rob", s_st_rob, 7);
            chk("store_rd_en", s_rd, (c == 2));
        end
        idle(1'b0);
        run_cycle();
        chk("store_req_dropped", s_st_req, 0);
        chk("store_req_cycles", hi_cnt, 3);

        // Mispredicted branch; the ready head during FLUSH must not retire
        drive(1'b0, IT_BRANCH, 4'd1, 32'h0000_0400, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle();
        chk("misp_rd_en", s_rd, 1);
        chk("misp_no_flush_yet", s_flush, 0);
        drive(1'b0, IT_REG, 4'd3, 32'h99, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle();
        chk("misp_flush", s_flush, 1);
        chk("misp_redirect", s_pc, 32'h400);
        chk("misp_cnt", s_mis, 1);
        chk("misp_flush_rd_en", s_rd, 0);
        idle(1'b0);
        run_cycle();
        chk("misp_flush_one_cycle", s_flush, 0);

        // Reset while waiting on a store aborts it
        drive(1'b0, IT_STORE, 4'd10, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle();
        drive(1'b1, IT_REG, 4'd0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_cycle();
        chk("rst_sw_rd_en", s_rd, 0);
        drive(1'b0, IT_REG, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle();
        chk("rst_sw_st_req", s_st_req, 0);
        chk("rst_sw_no_commit", s_rd, 0);
        chk("rst_sw_retired", s_ret, 0);

        // Reset during FLUSH: no further flush pulse
        drive(1'b0, IT_BRANCH, 4'd5, 32'h0000_0800, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle();
        idle(1'b1);
        run_cycle();
        idle(1'b0);
        run_cycle();
        chk("rst_fl_flush", s_flush, 0);
        chk("rst_fl_mis", s_mis, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  itype_t'($urandom_range(0, 3)),
                  4'($urandom()),
                  $urandom(),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
                  1'($urandom()),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 3));
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width.
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 head  input  ROB_entry_t  ROB head entry, combinational from ROB; uses itype, ROB_number, value, dest_reg[4:0], branch_result.
REQ-006 head_ready  input  1  head entry result is complete.
REQ-007 empty  input  1  ROB empty.
REQ-008 ROB_head_store  input  1  head itype == 2'b01.
REQ-009 rd_en  output  1  dequeue ROB head this cycle.
REQ-010 rf_we / rf_waddr / rf_wdata / rf_rob_tag  output  1/5/XLEN/4  architectural register write and its ROB tag.
REQ-011 st_req / st_rob  output  1/4  store commit request to load/store queue, with ROB number.
REQ-012 st_ack  input  1  store-queue acceptance, valid only while st_req=1.
REQ-013 flush / redirect_pc  output  1/XLEN  pipeline flush pulse and corrected PC.
REQ-014 retired_cnt / mispredict_cnt  output  CNT_W/16  performance counters.

Function
REQ-015 SHALL implement FSM states RUN, STORE_WAIT, FLUSH; reset state RUN.
REQ-016 RUN, commit condition: head_ready=1 and empty=0; otherwise rd_en, rf_we and st_req are 0.
REQ-017 RUN, itype[1]=1 (load/reg-dest): rd_en=1 and rf_we=1 combinationally in the same cycle; rf_waddr=head.dest_reg, rf_wdata=head.value, rf_rob_tag=head.ROB_number.
REQ-018 dest_reg==0: rf_we SHALL stay 0; rd_en still 1.
REQ-019 RUN, branch (itype=00), branch_result=0: rd_en=1, no other effect.
REQ-020 RUN, branch, branch_result=1 (mispredict): rd_en=1; next state FLUSH; redirect_pc registered from head.value.
REQ-021 FLUSH: flush=1 for exactly one cycle, rd_en=0; redirect_pc valid while flush=1; next state RUN.
REQ-022 RUN, store (ROB_head_store=1): rd_en=0; next state STORE_WAIT; st_rob registered from head.ROB_number.
REQ-023 STORE_WAIT: st_req=1 (registered) until st_ack; on st_ack cycle rd_en=1, st_req drops next edge, next state RUN.
REQ-024 Maximum one commit (rd_en pulse) per cycle; latency RUN reg-dest commit 0 cycles after head_ready, store at least 2 cycles.
REQ-025 retired_cnt SHALL increment by 1 on every cycle with rd_en=1; wraps modulo 2^CNT_W.
REQ-026 mispredict_cnt SHALL increment on entry to FLUSH; saturates at 16'hFFFF.
REQ-027 empty=1 SHALL block commit even when head_ready=1.
REQ-028 st_ack while not in STORE_WAIT SHALL be ignored.
REQ-029 In STORE_WAIT, head changes are ignored; st_rob is held.

Reset
REQ-030 reset SHALL force state RUN and set rd_en, rf_we, st_req, flush to 0; st_rob, redirect_pc, retired_cnt, mispredict_cnt to 0.
REQ-031 reset during STORE_WAIT or FLUSH SHALL abort the operation; no rd_en pulse and no flush pulse after the reset edge.

Structure
REQ-032 ROB_entry_t, itype encodings (BRANCH=00, STORE=01, REG/LOAD=1x) and commit FSM state enum SHALL live in the shared structs header.
REQ-033 SHALL be a single module; no sub-modules.

Verification
REQ-034 reg-dest head, dest_reg=5, value=32'hDEAD_BEEF, ready=1 -> same cycle rd_en=1, rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF; retired_cnt 0->1.
REQ-035 reg-dest head, dest_reg=0 -> rd_en=1, rf_we=0.
REQ-036 store head ROB_number=7, st_ack after 3 cycles -> st_req high 3 cycles, st_rob=7, rd_en=1 on ack cycle only.
REQ-037 mispredicted branch, value=32'h0000_0400 -> rd_en=1, next cycle flush=1 for one cycle with redirect_pc=0x400, mispredict_cnt=1.
REQ-038 head_ready=1 with empty=1 -> no rd_en; reset asserted in STORE_WAIT -> st_req=0 after next edge, no commit.
